// File: rtl/multdiv_if.sv
// Handshake bundle between the X-stage decode, the multiply/divide unit and
// the X/M capture logic, as seen by the multdiv_ctrl sequencer.
interface multdiv_if #(
  parameter int RD_W = 5
);
  logic            mult;
  logic            div;
  logic            flush;
  logic [31:0]     a_in;
  logic [31:0]     b_in;
  logic [RD_W-1:0] rd_in;
  logic            ctrl_mult;
  logic            ctrl_div;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic            unit_rdy;
  logic [31:0]     unit_result;
  logic            unit_exception;
  logic            stall;
  logic            busy;
  logic            result_valid;
  logic [31:0]     result;
  logic [RD_W-1:0] result_rd;
  logic            exception;

  modport slave (
    input  mult, div, flush, a_in, b_in, rd_in,
    input  unit_rdy, unit_result, unit_exception,
    output ctrl_mult, ctrl_div, op_a, op_b,
    output stall, busy, result_valid, result, result_rd, exception
  );

  modport master (
    output mult, div, flush, a_in, b_in, rd_in,
    output unit_rdy, unit_result, unit_exception,
    input  ctrl_mult, ctrl_div, op_a, op_b,
    input  stall, busy, result_valid, result, result_rd, exception
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle multiply/divide unit beside the X stage.
// Optional macro MULTDIV_PERF_EN adds a saturating stall-cycle counter output.
module multdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int RD_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  multdiv_if.slave    bus
`ifdef MULTDIV_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RD_W-1:0] rd_q;
  logic            start;
  logic            capture;
  logic            go_issue;
  logic            finish;
  logic            fin_exc;
  logic [31:0]     fin_result;

  // mult takes priority when both decode bits are set
  assign start = (bus.mult | bus.div) & ~bus.flush;

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    go_issue   = 1'b0;
    finish     = 1'b0;
    fin_exc    = 1'b0;
    fin_result = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (!bus.mult && bus.b_in == 32'd0) begin
            state_nxt = S_DONE;
            finish    = 1'b1;
            fin_exc   = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
            go_issue  = 1'b1;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.unit_rdy) begin
          state_nxt  = S_DONE;
          finish     = 1'b1;
          fin_result = bus.unit_result;
          fin_exc    = bus.unit_exception;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = S_DONE;
          finish    = 1'b1;
          fin_exc   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered outputs: start pulses and strobes live exactly one cycle,
  // operands and result hold until the next capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.ctrl_mult    <= 1'b0;
      bus.ctrl_div     <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.exception    <= 1'b0;
      bus.op_a         <= '0;
      bus.op_b         <= '0;
      bus.result       <= '0;
      rd_q             <= '0;
    end else begin
      bus.ctrl_mult    <= go_issue & bus.mult;
      bus.ctrl_div     <= go_issue & ~bus.mult;
      bus.result_valid <= finish;
      bus.exception    <= finish & fin_exc;
      if (capture) begin
        bus.op_a <= bus.a_in;
        bus.op_b <= bus.b_in;
        rd_q     <= bus.rd_in;
      end
      if (finish) begin
        bus.result <= fin_result;
      end
    end
  end

  assign bus.result_rd = rd_q;
  assign bus.stall     = (state == S_IDLE && start) || state == S_ISSUE || state == S_WAIT;
  assign bus.busy      = (state == S_ISSUE) || (state == S_WAIT);

`ifdef MULTDIV_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (bus.stall) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized bench for multdiv_ctrl: a D/X slot model, a behavioural unit and
// an outcome queue predict every start pulse and result strobe.
module tb_multdiv_ctrl;
  localparam int TIMEOUT = 40;
  localparam int RD_W    = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multdiv_if #(.RD_W(RD_W)) bus ();
`ifdef MULTDIV_PERF_EN
  logic [31:0] stall_cycles;
  longint      perf_model = 0;
`endif

  multdiv_ctrl #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MULTDIV_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // lat = WAIT cycle on which the unit answers; 0 means it never answers
  typedef struct {
    bit              m, d, f;
    logic [31:0]     a, b;
    logic [RD_W-1:0] rd;
    int              lat;
    logic [31:0]     ures;
    bit              uexc;
  } instr_t;
  typedef struct {
    int              due;
    logic [31:0]     res;
    logic [RD_W-1:0] rd;
    bit              exc;
  } exp_t;
  typedef struct {
    int          due;
    bit          is_mult;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] ures;
    bit          uexc;
  } iss_t;

  instr_t prog[$];
  instr_t dx;
  exp_t   expq[$];
  iss_t   issq[$];
  iss_t   u_cur;
  bit     u_pend = 1'b0;
  int     u_cnt = 0;
  bit     noise_en = 1'b0;
  int     force_rdy_cyc = -1;
  int     cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  logic   stall_s = 1'b0;
  int     ph_stall, ph_busy, ph_pm, ph_pd, ph_valid, exp_stall, exp_busy;
  logic [31:0]     last_res;
  logic [RD_W-1:0] last_rd, first_rd;
  bit              last_exc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic instr_t mk(bit m, bit d, bit f, logic [31:0] a, logic [31:0] b,
                                logic [RD_W-1:0] rd, int lat, logic [31:0] ures, bit uexc);
    instr_t i;
    i.m = m; i.d = d; i.f = f; i.a = a; i.b = b; i.rd = rd;
    i.lat = lat; i.ures = ures; i.uexc = uexc;
    return i;
  endfunction

  function automatic instr_t bubble();
    return mk(0, 0, 0, $urandom, $urandom, RD_W'($urandom), 0, 0, 0);
  endfunction

  task automatic clr_ph();
    ph_stall = 0; ph_busy = 0; ph_pm = 0; ph_pd = 0; ph_valid = 0;
    exp_stall = 0; exp_busy = 0;
  endtask

  // Outcome of one instruction evaluated in X, straight from the rules
  task automatic model_accept(input instr_t in);
    exp_t e;
    iss_t s;
    int   w;
    if (!((in.m || in.d) && !in.f)) return;
    e.rd = in.rd;
    if (!in.m && in.b == 32'd0) begin
      e.due = cyc + 1; e.res = 0; e.exc = 1'b1;
      exp_stall += 1;
    end else begin
      w = (in.lat != 0) ? in.lat : TIMEOUT;
      e.due = cyc + 2 + w;
      e.res = (in.lat != 0) ? in.ures : 32'd0;
      e.exc = (in.lat != 0) ? in.uexc : 1'b1;
      s.due = cyc + 1; s.is_mult = in.m; s.a = in.a; s.b = in.b;
      s.lat = in.lat; s.ures = in.ures; s.uexc = in.uexc;
      issq.push_back(s);
      exp_stall += 2 + w;
      exp_busy  += 1 + w;
    end
    expq.push_back(e);
  endtask

  task automatic drive_dx();
    bus.mult = dx.m; bus.div = dx.d; bus.flush = dx.f;
    bus.a_in = dx.a; bus.b_in = dx.b; bus.rd_in = dx.rd;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (!stall_s) begin
      dx = (prog.size() != 0) ? prog.pop_front() : bubble();
      model_accept(dx);
    end
    drive_dx();
    bus.unit_rdy       = 1'b0;
    bus.unit_result    = $urandom;
    bus.unit_exception = 1'($urandom_range(1));
    if (u_pend) begin
      u_cnt++;
      if (u_cur.lat != 0 && u_cnt == u_cur.lat) begin
        bus.unit_rdy = 1'b1; bus.unit_result = u_cur.ures; bus.unit_exception = u_cur.uexc;
        u_pend = 1'b0;
      end else if (u_cur.lat == 0 && u_cnt == TIMEOUT) begin
        u_pend = 1'b0;
      end
    end else if (noise_en && $urandom_range(7) == 0) begin
      bus.unit_rdy = 1'b1;
    end
    if (cyc == force_rdy_cyc) begin
      bus.unit_rdy = 1'b1; bus.unit_result = 32'h1234; bus.unit_exception = 1'b1;
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    dx = bubble();
    drive_dx();
    bus.unit_rdy = 1'b0;
    expq.delete(); issq.delete(); u_pend = 1'b0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_b", bus.op_b, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_rd", bus.result_rd, 0);
    chk("rst_ctrl_mult", bus.ctrl_mult, 0);
    chk("rst_ctrl_div", bus.ctrl_div, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_exception", bus.exception, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b1;
    clr_ph();
`ifdef MULTDIV_PERF_EN
    perf_model = 0;
`endif
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((prog.size() != 0 || expq.size() != 0 || issq.size() != 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_bound: %0d ops still pending after %0d cycles, required 0",
               expq.size() + issq.size() + prog.size(), n);
      prog.delete(); expq.delete(); issq.delete();
    end
    repeat (3) step();
    chk("stall_total", ph_stall, exp_stall);
    chk("busy_total", ph_busy, exp_busy);
  endtask

  // Per-cycle comparison against the predicted pulses and result strobes
  always @(negedge clk) begin
    iss_t s;
    exp_t e;
    stall_s = bus.stall;
    if (reset) begin
      if (bus.stall) ph_stall++;
      if (bus.busy) ph_busy++;
`ifdef MULTDIV_PERF_EN
      if (bus.stall) perf_model++;
`endif
      if (bus.ctrl_mult || bus.ctrl_div) begin
        if (bus.ctrl_mult) ph_pm++;
        if (bus.ctrl_div) ph_pd++;
        if (issq.size() == 0) begin
          chk("unexpected_pulse", {bus.ctrl_mult, bus.ctrl_div}, 0);
        end else begin
          s = issq.pop_front();
          chk("pulse_cycle", cyc, s.due);
          chk("ctrl_mult", bus.ctrl_mult, s.is_mult);
          chk("ctrl_div", bus.ctrl_div, !s.is_mult);
          chk("op_a", bus.op_a, s.a);
          chk("op_b", bus.op_b, s.b);
          u_cur = s; u_cnt = 0; u_pend = 1'b1;
        end
      end
      if (bus.result_valid) begin
        if (ph_valid == 0) first_rd = bus.result_rd;
        ph_valid++;
        last_res = bus.result; last_rd = bus.result_rd; last_exc = bus.exception;
        if (expq.size() == 0) begin
          chk("unexpected_valid", bus.result_valid, 0);
        end else begin
          e = expq.pop_front();
          chk("valid_cycle", cyc, e.due);
          chk("result", bus.result, e.res);
          chk("result_rd", bus.result_rd, e.rd);
          chk("exception", bus.exception, e.exc);
        end
      end else begin
        chk("exc_without_valid", bus.exception, 0);
      end
      if (expq.size() != 0 && cyc > expq[0].due) begin
        e = expq.pop_front();
        chk("missing_valid", 0, 1);
      end
    end
  end

  initial begin
    int guard;
    instr_t r;
    int k, lsel;
    dx = bubble();
    drive_dx();
    bus.unit_rdy = 1'b0; bus.unit_result = 0; bus.unit_exception = 1'b0;
    clr_ph();
    apply_reset(2);

    // mult 7*6, unit answers on third WAIT cycle
    clr_ph();
    prog.push_back(mk(1, 0, 0, 7, 6, 5, 3, 42, 0));
    drain(200);
    chk("t1_pulses_mult", ph_pm, 1);
    chk("t1_pulses_div", ph_pd, 0);
    chk("t1_stall_cycles", ph_stall, 5);
    chk("t1_valid_count", ph_valid, 1);
    chk("t1_result", last_res, 42);
    chk("t1_rd", last_rd, 5);
    chk("t1_exc", last_exc, 0);
    chk("t1_result_hold", bus.result, 42);
    chk("t1_rd_hold", bus.result_rd, 5);

    // divide by zero
    clr_ph();
    prog.push_back(mk(0, 1, 0, 100, 0, 3, 2, 77, 0));
    drain(200);
    chk("t2_pulses", ph_pm + ph_pd, 0);
    chk("t2_stall_cycles", ph_stall, 1);
    chk("t2_valid_count", ph_valid, 1);
    chk("t2_result", last_res, 0);
    chk("t2_rd", last_rd, 3);
    chk("t2_exc", last_exc, 1);

    // unit never answers
    clr_ph();
    prog.push_back(mk(0, 1, 0, 100, 7, 9, 0, 0, 0));
    drain(200);
    chk("t3_pulses_div", ph_pd, 1);
    chk("t3_stall_cycles", ph_stall, 42);
    chk("t3_busy_cycles", ph_busy, 41);
    chk("t3_result", last_res, 0);
    chk("t3_exc", last_exc, 1);
    chk("t3_idle_busy", bus.busy, 0);

    // flushed mult
    clr_ph();
    prog.push_back(mk(1, 0, 1, 7, 6, 2, 1, 42, 0));
    drain(200);
    chk("t4_pulses", ph_pm + ph_pd, 0);
    chk("t4_stall_cycles", ph_stall, 0);
    chk("t4_valid_count", ph_valid, 0);

    // answer on the last WAIT cycle beats the timeout
    clr_ph();
    prog.push_back(mk(1, 0, 0, 1, 2, 12, 40, 32'hDEAD, 1));
    drain(200);
    chk("t7_stall_cycles", ph_stall, 42);
    chk("t7_result", last_res, 32'hDEAD);
    chk("t7_exc", last_exc, 1);

    // mult and div together with b=0: mult wins
    clr_ph();
    prog.push_back(mk(1, 1, 0, 9, 0, 6, 2, 0, 0));
    drain(200);
    chk("t8_pulses_mult", ph_pm, 1);
    chk("t8_pulses_div", ph_pd, 0);
    chk("t8_stall_cycles", ph_stall, 4);

    // back-to-back mults, second waits in D/X
    clr_ph();
    prog.push_back(mk(1, 0, 0, 3, 4, 10, 2, 12, 0));
    prog.push_back(mk(1, 0, 0, 5, 6, 11, 1, 30, 0));
    drain(200);
    chk("t6_valid_count", ph_valid, 2);
    chk("t6_pulses_mult", ph_pm, 2);
    chk("t6_stall_cycles", ph_stall, 7);
    chk("t6_first_rd", first_rd, 10);
    chk("t6_last_rd", last_rd, 11);
    chk("t6_last_result", last_res, 30);

    // reset during WAIT, stray unit_rdy afterwards
    clr_ph();
    prog.push_back(mk(1, 0, 0, 8, 8, 4, 0, 0, 0));
    guard = 0;
    while (!bus.busy && guard < 10) begin
      step();
      guard++;
    end
    chk("t5_reached_busy", bus.busy, 1);
    repeat (5) step();
    apply_reset(2);
    force_rdy_cyc = cyc + 2;
    repeat (6) step();
    chk("t5_valid_count", ph_valid, 0);
    chk("t5_pulses", ph_pm + ph_pd, 0);
    chk("t5_result", bus.result, 0);
    chk("t5_rd", bus.result_rd, 0);
    chk("t5_op_a", bus.op_a, 0);
    chk("t5_stall", ph_stall, 0);
    force_rdy_cyc = -1;

    // random instruction stream with spurious unit_rdy noise
    clr_ph();
    noise_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = bubble();
      k = $urandom_range(9);
      r.m = (k >= 2 && k <= 5) || k == 9;
      r.d = (k >= 6);
      if (r.d && $urandom_range(3) == 0) r.b = 0;
      r.f = ($urandom_range(5) == 0);
      lsel = $urandom_range(11);
      r.lat = (lsel == 0) ? 0 : (lsel == 1) ? 40 : (lsel == 2) ? 39 : $urandom_range(6, 1);
      r.ures = $urandom;
      r.uexc = 1'($urandom_range(1));
      prog.push_back(r);
    end
    drain(20000);
    noise_en = 1'b0;
`ifdef MULTDIV_PERF_EN
    chk("stall_cycles_ctr", stall_cycles, perf_model[31:0]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
